apple_ctrl: RTL

Sequencer for the apple position generator. It detects the snake head reaching the apple and pulses the generator for a new pseudo-random candidate. It then scans the snake body store to reject candidates lying on the body and publishes a validated apple position plus score. It sits between the snake body/motion logic, the apple generator and the VGA renderer, all on the 25 MHz domain.

---
 rtl/apple_ctrl_pkg.sv | 21 ++
 rtl/apple_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/apple_ctrl_pkg.sv
// Shared definitions for the apple sequencer and the apple position generator.
package apple_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_SCAN,
    ST_DONE
  } state_t;

  // Power-up apple position; the generator resets to the same point.
  localparam logic [6:0] APPLE_RST_X = 7'd75;
  localparam logic [5:0] APPLE_RST_Y = 6'd30;

  localparam logic [7:0] SCORE_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == SCORE_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/apple_ctrl.sv
// Apple sequencer: detects eats, requests candidates, scans the body store to reject them.
// Clean regeneration takes len+3 cycles from apple_eaten to apple_valid; game_en low aborts to IDLE.
module apple_ctrl
  import apple_ctrl_pkg::*;
#(
  parameter int MAX_LEN   = 32,
  parameter int MAX_RETRY = 15
) (
  input  logic                       clk_25M,
  input  logic                       rst,
  input  logic                       game_en,
  input  logic [6:0]                 head_x,
  input  logic [5:0]                 head_y,
  input  logic [5:0]                 snake_len,
  input  logic [6:0]                 apple_x_pos,
  input  logic [5:0]                 apple_y_pos,
  output logic                       apple_gen,
  output logic [$clog2(MAX_LEN)-1:0] body_rd_addr,
  input  logic [6:0]                 body_x,
  input  logic [5:0]                 body_y,
  output logic                       apple_valid,
  output logic                       apple_eaten,
  output logic                       gen_timeout,
  output logic [7:0]                 score
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [6:0]    LEN_CAP   = 7'(MAX_LEN);
  localparam logic [RW-1:0] RETRY_CAP = RW'(MAX_RETRY);

  state_t        state_q, state_d;
  logic [6:0]    len_q, len_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          valid_q, valid_d;
  logic          eaten_q, eaten_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    score_q, score_d;

  logic head_hit, body_hit, scan_last, eat, retry_left;

  assign head_hit   = (head_x == apple_x_pos) && (head_y == apple_y_pos);
  // cnt_q lags the issued address by one, so data is valid from cnt_q = 1 on.
  assign body_hit   = (cnt_q != 7'd0) && (body_x == apple_x_pos) && (body_y == apple_y_pos);
  assign scan_last  = (cnt_q == len_q);
  assign eat        = (state_q == ST_IDLE) && game_en && valid_q && head_hit;
  assign retry_left = (retry_q != RETRY_CAP);

  always_ff @(posedge clk_25M or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!game_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_q && head_hit) state_d = ST_GEN;
          else if (!valid_q)       state_d = ST_SCAN;
        end
        ST_GEN:  state_d = ST_SCAN;
        ST_SCAN: begin
          if (body_hit)       state_d = retry_left ? ST_GEN : ST_DONE;
          else if (scan_last) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    apple_gen    = (state_q == ST_GEN);
    body_rd_addr = '0;
    if (state_q == ST_SCAN && cnt_q < len_q) body_rd_addr = cnt_q[AW-1:0];
  end

  always_comb begin
    cnt_d     = (state_q == ST_SCAN && state_d == ST_SCAN) ? cnt_q + 7'd1 : 7'd0;
    len_d     = len_q;
    retry_d   = retry_q;
    valid_d   = valid_q;
    eaten_d   = eat;
    score_d   = eat ? sat_inc8(score_q) : score_q;
    timeout_d = (state_q == ST_SCAN) && game_en && body_hit && !retry_left;
    if (state_q != ST_SCAN && state_d == ST_SCAN)
      len_d = ({1'b0, snake_len} > LEN_CAP) ? LEN_CAP : {1'b0, snake_len};
    if (eat || (state_q == ST_DONE && game_en))
      retry_d = '0;
    else if (state_q == ST_SCAN && game_en && body_hit && retry_left)
      retry_d = retry_q + 1'b1;
    if (eat)                                valid_d = 1'b0;
    else if (state_q == ST_DONE && game_en) valid_d = 1'b1;
  end

  always_ff @(posedge clk_25M or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      retry_q   <= '0;
      valid_q   <= 1'b0;
      eaten_q   <= 1'b0;
      timeout_q <= 1'b0;
      score_q   <= '0;
    end else begin
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      valid_q   <= valid_d;
      eaten_q   <= eaten_d;
      timeout_q <= timeout_d;
      score_q   <= score_d;
    end
  end

  assign apple_valid = valid_q;
  assign apple_eaten = eaten_q;
  assign gen_timeout = timeout_q;
  assign score       = score_q;

endmodule
